// File: rtl/udp_rx_ctrl_fsm.sv
// udp_rx_ctrl_fsm -- receive-control FSM for the UDP packet parser.
//
// Purpose: sequences header capture, a one-cycle header-latch, the
// accept/drop decision and payload forward/drop for one packet at a time.
// Keeps its own byte counter (header-done is derived from it), applies
// input back-pressure during the latch/decision cycles, checks the UDP
// length, detects truncated headers and idle timeouts, and reports a
// per-packet completion code plus forwarded/dropped packet statistics.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_valid/s_last  input beat handshake and end-of-packet marker
//   s_bytes         valid bytes on the last beat (other beats are full)
//   s_ready         beat accepted when s_valid && s_ready
//   port_hit        per-entry destination-port match from the header parser
//   checksum_ok     header parser checksum result
//   udp_len         UDP length field from the header parser
//   parse_enable    header parser captures the current beat
//   latch_outputs   header parser latches its outputs
//   fwd_enable      forward payload beats
//   drop_enable     discard payload beats
//   port_sel        lowest matching port-table index
//   byte_count      bytes accepted in the current/last packet (saturating)
//   pkt_done        one-cycle completion pulse
//   pkt_status      completion code, valid with and held after pkt_done
//                   0 ok, 1 checksum, 2 no port, 3 truncated, 4 length
//                   mismatch, 5 idle timeout, 6 udp_len shorter than header
//   fwd_pkts        forwarded packet count (wraps)
//   drop_pkts       dropped/aborted packet count (wraps)
// NUM_PORTS must be at least 2.

module udp_rx_ctrl_fsm #(
  parameter int BYTES_PER_BEAT = 1,
  parameter int HDR_BYTES      = 8,
  parameter int NUM_PORTS      = 4,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYC    = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  input  logic                                  s_last,
  input  logic [$clog2(BYTES_PER_BEAT+1)-1:0]   s_bytes,
  output logic                                  s_ready,
  input  logic [NUM_PORTS-1:0]                  port_hit,
  input  logic                                  checksum_ok,
  input  logic [LEN_W-1:0]                      udp_len,
  output logic                                  parse_enable,
  output logic                                  latch_outputs,
  output logic                                  fwd_enable,
  output logic                                  drop_enable,
  output logic [$clog2(NUM_PORTS)-1:0]          port_sel,
  output logic [LEN_W-1:0]                      byte_count,
  output logic                                  pkt_done,
  output logic [2:0]                            pkt_status,
  output logic [31:0]                           fwd_pkts,
  output logic [31:0]                           drop_pkts
);

  localparam int PS_W = $clog2(NUM_PORTS);
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HEADER  = 3'd1;
  localparam logic [2:0] LATCH   = 3'd2;
  localparam logic [2:0] CHECK   = 3'd3;
  localparam logic [2:0] FORWARD = 3'd4;
  localparam logic [2:0] DROP    = 3'd5;

  logic [2:0]       state_reg, state_next;
  logic [LEN_W-1:0] byte_count_reg, byte_count_next;
  logic [LEN_W-1:0] udp_len_reg, udp_len_next;
  logic [PS_W-1:0]  port_sel_reg, port_sel_next;
  logic [2:0]       drop_code_reg, drop_code_next;
  logic             hdr_last_reg, hdr_last_next;
  logic [TO_W-1:0]  idle_cnt_reg, idle_cnt_next;
  logic             pkt_done_reg, done_next;
  logic [2:0]       pkt_status_reg, status_next;
  logic [31:0]      fwd_pkts_reg, drop_pkts_reg;

  logic             acc;
  logic [LEN_W-1:0] beat_bytes, cnt_base, cnt_acc;
  logic [LEN_W:0]   cnt_sum;
  logic             hdr_done, timing_state, timeout;
  logic [NUM_PORTS-1:0] hit_below, first_hit;
  logic [PS_W-1:0]  hit_sel;
  logic             reject;
  logic [2:0]       reject_code;

  // Everything reads as zero while reset is held, including s_ready.
  assign s_ready       = !rst && (state_reg == IDLE || state_reg == HEADER ||
                                  state_reg == FORWARD || state_reg == DROP);
  assign acc           = s_valid && s_ready;
  assign parse_enable  = !rst && (state_reg == IDLE || state_reg == HEADER) && s_valid;
  assign latch_outputs = !rst && (state_reg == LATCH);
  assign fwd_enable    = !rst && (state_reg == FORWARD);
  assign drop_enable   = !rst && (state_reg == DROP);
  assign port_sel      = port_sel_reg;
  assign byte_count    = byte_count_reg;
  assign pkt_done      = pkt_done_reg;
  assign pkt_status    = pkt_status_reg;
  assign fwd_pkts      = fwd_pkts_reg;
  assign drop_pkts     = drop_pkts_reg;

  // Only the last beat may be partial. The first beat of a packet (IDLE)
  // restarts the count instead of adding to the previous packet's total.
  assign beat_bytes = s_last ? LEN_W'(s_bytes) : LEN_W'(BYTES_PER_BEAT);
  assign cnt_base   = (state_reg == IDLE) ? '0 : byte_count_reg;
  assign cnt_sum    = {1'b0, cnt_base} + {1'b0, beat_bytes};
  assign cnt_acc    = cnt_sum[LEN_W] ? '1 : cnt_sum[LEN_W-1:0];
  assign hdr_done   = cnt_acc >= LEN_W'(HDR_BYTES);

  // Idle timer covers the states where the packet is waiting on input.
  assign timing_state = (state_reg == HEADER || state_reg == FORWARD || state_reg == DROP);
  assign timeout      = (TIMEOUT_CYC > 0) && timing_state && !acc && (idle_cnt_reg == TO_LAST);

  // Lowest-index match wins: isolate the first set bit, then encode it.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_prio
    if (gi == 0) begin : g_first
      assign hit_below[gi] = 1'b0;
    end else begin : g_rest
      assign hit_below[gi] = hit_below[gi-1] | port_hit[gi-1];
    end
    assign first_hit[gi] = port_hit[gi] & ~hit_below[gi];
  end

  always_comb begin
    hit_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (first_hit[i]) hit_sel = PS_W'(i);
    end
  end

  // Drop reasons in priority order: short length, no port, bad checksum.
  always_comb begin
    reject      = 1'b1;
    reject_code = 3'd0;
    if (udp_len < LEN_W'(HDR_BYTES))  reject_code = 3'd6;
    else if (port_hit == '0)           reject_code = 3'd2;
    else if (!checksum_ok)             reject_code = 3'd1;
    else                               reject      = 1'b0;
  end

  always_comb begin
    state_next      = state_reg;
    byte_count_next = acc ? cnt_acc : byte_count_reg;
    udp_len_next    = udp_len_reg;
    port_sel_next   = port_sel_reg;
    drop_code_next  = drop_code_reg;
    hdr_last_next   = hdr_last_reg;
    idle_cnt_next   = '0;
    done_next       = 1'b0;
    status_next     = pkt_status_reg;
    if ((TIMEOUT_CYC > 0) && timing_state && !acc) idle_cnt_next = idle_cnt_reg + 1'b1;

    case (state_reg)
      IDLE, HEADER: begin
        if (acc) begin
          if (hdr_done) begin
            state_next    = LATCH;
            hdr_last_next = s_last;
          end else if (s_last) begin
            state_next  = IDLE;
            done_next   = 1'b1;
            status_next = 3'd3;
          end else begin
            state_next = HEADER;
          end
        end else if (timeout) begin
          state_next  = IDLE;
          done_next   = 1'b1;
          status_next = 3'd5;
        end
      end
      LATCH: state_next = CHECK;
      CHECK: begin
        udp_len_next   = udp_len;
        port_sel_next  = hit_sel;
        drop_code_next = reject_code;
        if (hdr_last_reg) begin
          // Header-only packet: nothing left to stream, finish here.
          state_next  = IDLE;
          done_next   = 1'b1;
          status_next = reject ? reject_code
                               : ((udp_len == LEN_W'(HDR_BYTES)) ? 3'd0 : 3'd4);
        end else begin
          state_next = reject ? DROP : FORWARD;
        end
      end
      FORWARD, DROP: begin
        if (acc && s_last) begin
          state_next  = IDLE;
          done_next   = 1'b1;
          if (state_reg == DROP) status_next = drop_code_reg;
          else                   status_next = (cnt_acc != udp_len_reg) ? 3'd4 : 3'd0;
        end else if (timeout) begin
          state_next  = IDLE;
          done_next   = 1'b1;
          status_next = 3'd5;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      byte_count_reg <= '0;
      udp_len_reg    <= '0;
      port_sel_reg   <= '0;
      drop_code_reg  <= '0;
      hdr_last_reg   <= 1'b0;
      idle_cnt_reg   <= '0;
      pkt_done_reg   <= 1'b0;
      pkt_status_reg <= '0;
      fwd_pkts_reg   <= '0;
      drop_pkts_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      byte_count_reg <= byte_count_next;
      udp_len_reg    <= udp_len_next;
      port_sel_reg   <= port_sel_next;
      drop_code_reg  <= drop_code_next;
      hdr_last_reg   <= hdr_last_next;
      idle_cnt_reg   <= idle_cnt_next;
      pkt_done_reg   <= done_next;
      if (done_next) begin
        pkt_status_reg <= status_next;
        // Status 0/4 only arise from accepted packets; all else is a drop.
        if (status_next == 3'd0 || status_next == 3'd4) fwd_pkts_reg  <= fwd_pkts_reg + 32'd1;
        else                                            drop_pkts_reg <= drop_pkts_reg + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_udp_rx_ctrl_fsm.sv
module tb_udp_rx_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, s_valid, s_last, use4, checksum_ok;
  logic [3:0]  sb, port_hit;
  logic [15:0] udp_len;
  logic        v1, v4;
  logic [0:0]  sb1;
  logic [2:0]  sb4;

  assign v1  = s_valid & ~use4;
  assign v4  = s_valid & use4;
  assign sb1 = sb[0:0];
  assign sb4 = sb[2:0];

  logic        rdy1, pe1, lo1, fe1, de1, done1;
  logic [1:0]  ps1;
  logic [15:0] bc1;
  logic [2:0]  st1;
  logic [31:0] fp1, dp1;
  logic        rdy4, pe4, lo4, fe4, de4, done4;
  logic [1:0]  ps4;
  logic [15:0] bc4;
  logic [2:0]  st4;
  logic [31:0] fp4, dp4;

  udp_rx_ctrl_fsm #(.BYTES_PER_BEAT(1), .HDR_BYTES(8), .NUM_PORTS(4), .LEN_W(16), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .s_valid(v1), .s_last(s_last), .s_bytes(sb1), .s_ready(rdy1),
    .port_hit(port_hit), .checksum_ok(checksum_ok), .udp_len(udp_len),
    .parse_enable(pe1), .latch_outputs(lo1), .fwd_enable(fe1), .drop_enable(de1),
    .port_sel(ps1), .byte_count(bc1), .pkt_done(done1), .pkt_status(st1),
    .fwd_pkts(fp1), .drop_pkts(dp1));

  udp_rx_ctrl_fsm #(.BYTES_PER_BEAT(4), .HDR_BYTES(8), .NUM_PORTS(4), .LEN_W(16), .TIMEOUT_CYC(16)) dut4 (
    .clk(clk), .rst(rst), .s_valid(v4), .s_last(s_last), .s_bytes(sb4), .s_ready(rdy4),
    .port_hit(port_hit), .checksum_ok(checksum_ok), .udp_len(udp_len),
    .parse_enable(pe4), .latch_outputs(lo4), .fwd_enable(fe4), .drop_enable(de4),
    .port_sel(ps4), .byte_count(bc4), .pkt_done(done4), .pkt_status(st4),
    .fwd_pkts(fp4), .drop_pkts(dp4));

  logic rdy, fe, de, lo;
  assign rdy = use4 ? rdy4 : rdy1;
  assign fe  = use4 ? fe4 : fe1;
  assign de  = use4 ? de4 : de1;
  assign lo  = use4 ? lo4 : lo1;

  typedef struct {
    int dut;
    int status;
    int count;
    int psel;
    int fwd;
    int drop;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ef[2];
  int ed[2];
  int stall_cyc = 0, fwd_cyc = 0, drop_cyc = 0, latch_cyc = 0;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", tag, act, $time);
    end
  endtask

  // Expected completion for the packet about to be driven on the selected DUT.
  task automatic push_exp(input int status, input int count, input int psel);
    exp_t e;
    int d;
    d = use4 ? 1 : 0;
    if (status == 0 || status == 4) ef[d]++;
    else                            ed[d]++;
    e.dut = d; e.status = status; e.count = count; e.psel = psel;
    e.fwd = ef[d]; e.drop = ed[d];
    sb_q.push_back(e);
  endtask

  task automatic check_done(input int d, input logic [2:0] st, input logic [15:0] bc,
                            input logic [1:0] ps, input logic [31:0] fp, input logic [31:0] dp);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("unexpected_done", d, -1);
    end else begin
      e = sb_q.pop_front();
      check_eq("done_dut", d, e.dut);
      check_eq("pkt_status", st, e.status);
      check_eq("byte_count", bc, e.count);
      check_eq("port_sel", ps, e.psel);
      check_eq("fwd_pkts", fp, e.fwd);
      check_eq("drop_pkts", dp, e.drop);
    end
  endtask

  // Drive one beat and hold it until accepted; returns on the following negedge.
  task automatic beat(input logic last, input int nb);
    int g;
    g = 0;
    s_valid = 1'b1; s_last = last; sb = 4'(nb);
    #1;
    while (!rdy && g < 32) begin
      @(negedge clk); #1; g++;
    end
    if (g >= 32) check_eq("ready_wait_expired", g, 0);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic pkt1(input int nbytes, input logic with_last);
    for (int i = 0; i < nbytes; i++) beat(with_last && (i == nbytes - 1), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, f0, d0, l0;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; use4 = 1'b0; sb = 4'd0;
    port_hit = 4'd0; checksum_ok = 1'b0; udp_len = 16'd0;
    ef[0] = 0; ef[1] = 0; ed[0] = 0; ed[1] = 0;

    fork
      forever begin
        @(negedge clk); #2;
        if (s_valid && !rdy) stall_cyc++;
        if (fe) fwd_cyc++;
        if (de) drop_cyc++;
        if (lo) latch_cyc++;
        if (done1) check_done(0, st1, bc1, ps1, fp1, dp1);
        if (done4) check_done(1, st4, bc4, ps4, fp4, dp4);
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_eq("rst_s_ready", rdy1, 0);
    check_eq("rst_byte_count", bc1, 0);
    check_eq("rst_status_done", {st1, done1}, 0);
    check_eq("rst_counters4", {fp4, dp4}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_s_ready", rdy1, 1);

    // Forwarded packet, 8 header + 4 payload bytes.
    s0 = stall_cyc; f0 = fwd_cyc; d0 = drop_cyc; l0 = latch_cyc;
    port_hit = 4'b0100; checksum_ok = 1'b1; udp_len = 16'd12;
    push_exp(0, 12, 2);
    pkt1(12, 1);
    idle(3);
    check_eq("t1_stall_cycles", stall_cyc - s0, 2);
    check_eq("t1_fwd_cycles", fwd_cyc - f0, 4);
    check_eq("t1_drop_cycles", drop_cyc - d0, 0);
    check_eq("t1_latch_pulses", latch_cyc - l0, 1);

    // Same packet, bad checksum.
    f0 = fwd_cyc; d0 = drop_cyc;
    checksum_ok = 1'b0;
    push_exp(1, 12, 2);
    pkt1(12, 1);
    idle(3);
    check_eq("t2_drop_cycles", drop_cyc - d0, 4);
    check_eq("t2_fwd_cycles", fwd_cyc - f0, 0);

    // Truncated header: s_last on byte 5, port_sel holds its old value.
    l0 = latch_cyc;
    push_exp(3, 5, 2);
    pkt1(5, 1);
    idle(3);
    check_eq("t3_latch_pulses", latch_cyc - l0, 0);

    // Idle timeout in FORWARD after one payload byte.
    port_hit = 4'b0001; checksum_ok = 1'b1; udp_len = 16'd12;
    push_exp(5, 9, 0);
    pkt1(9, 0);
    idle(16);
    idle(3);

    // s_last arrives on the 16th idle-counted cycle: completes normally.
    push_exp(0, 12, 0);
    pkt1(11, 0);
    idle(15);
    beat(1'b1, 1);
    idle(3);

    // Priority: short length beats missing port and bad checksum.
    port_hit = 4'b0000; checksum_ok = 1'b0; udp_len = 16'd6;
    push_exp(6, 10, 0);
    pkt1(10, 1);
    idle(3);

    // Same packet again, reset while in DROP: no completion expected.
    d0 = drop_cyc;
    pkt1(10, 0);
    check_eq("t7_drop_cycles", drop_cyc - d0, 2);
    rst = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    check_eq("midrst_drop_enable", de1, 0);
    check_eq("midrst_s_ready", rdy1, 0);
    check_eq("midrst_byte_count", bc1, 0);
    check_eq("midrst_drop_pkts", dp1, 0);
    check_eq("midrst_fwd_pkts", fp1, 0);
    check_eq("midrst_status_done", {st1, done1}, 0);
    rst = 1'b0;
    ef[0] = 0; ed[0] = 0; ef[1] = 0; ed[1] = 0;
    idle(5);

    // 4-byte beats: 2 header beats then a 3-byte last beat, udp_len 12.
    use4 = 1'b1;
    port_hit = 4'b0010; checksum_ok = 1'b1; udp_len = 16'd12;
    push_exp(4, 11, 1);
    beat(1'b0, 4); beat(1'b0, 4); beat(1'b1, 3);
    // Back-to-back header-only packet with exact length.
    port_hit = 4'b1000; udp_len = 16'd8;
    push_exp(0, 8, 3);
    beat(1'b0, 4); beat(1'b1, 4);
    idle(3);
    // Header-only accept with a longer udp_len reports a length mismatch.
    udp_len = 16'd20;
    push_exp(4, 8, 3);
    beat(1'b0, 4); beat(1'b1, 4);
    idle(5);

    check_eq("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/udp_rx_ctrl_fsm.md
Name: udp_rx_ctrl_fsm

Overview:
- Parametrised receive-control FSM for the UDP packet parser. Sequences header capture, the header-latch cycle, the accept/drop decision, and payload forward/drop.
- Generalised over multi-byte beats and a multi-entry port-match table. Keeps its own byte counter and derives header-done internally.
- Adds input back-pressure, length checking, truncation and idle-timeout handling, per-packet completion status and packet statistics.
- Sits between the input stream and the header parser / payload forwarder.

Parameters:
- BYTES_PER_BEAT, 1, bytes per input beat; legal values 1, 2, 4, 8.
- HDR_BYTES, 8, UDP header length in bytes; must be a multiple of BYTES_PER_BEAT.
- NUM_PORTS, 4, number of entries in the port-match table.
- LEN_W, 16, width of the byte counter and length field.
- TIMEOUT_CYC, 1024, idle cycles mid-packet before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_valid  in  1  input beat valid
- s_last  in  1  final beat of packet
- s_bytes  in  $clog2(BYTES_PER_BEAT+1)  valid bytes on beat; sampled only on the last beat, all other beats count as BYTES_PER_BEAT
- s_ready  out  1  controller accepts beat
- port_hit  in  NUM_PORTS  per-entry destination-port match from header parser
- checksum_ok  in  1  header parser checksum result
- udp_len  in  LEN_W  UDP length field from header parser
- parse_enable  out  1  header parser captures the beat
- latch_outputs  out  1  header parser latches its outputs
- fwd_enable  out  1  forward payload beats
- drop_enable  out  1  discard payload beats
- port_sel  out  $clog2(NUM_PORTS)  matched table index
- byte_count  out  LEN_W  bytes accepted in current/last packet
- pkt_done  out  1  one-cycle completion pulse
- pkt_status  out  3  completion code, valid with and held after pkt_done
- fwd_pkts  out  32  forwarded packet count
- drop_pkts  out  32  dropped/aborted packet count

Behaviour:
- Reset: synchronous, active-high. state=IDLE; all outputs 0; captured udp_len and idle counter 0.
- Accepted beat ("acc") = s_valid && s_ready.
- s_ready = 1 in IDLE, HEADER, FORWARD, DROP; 0 in LATCH and CHECK, a fixed 2-cycle stall per packet.
- byte_count:
  - loaded with the beat byte count on the first acc of a packet, then incremented by the beat byte count on each acc;
  - saturates at 2^LEN_W-1;
  - holds after packet end until the next packet's first beat.
- States:
  - IDLE: acc → HEADER, or → LATCH if the beat already completes HDR_BYTES (BYTES_PER_BEAT==HDR_BYTES).
  - HEADER: acc where byte_count + beat bytes reaches HDR_BYTES → LATCH. s_last before that point → IDLE, status 3 (truncated).
  - LATCH: one cycle; latch_outputs=1; → CHECK.
  - CHECK: registers udp_len and port_sel (lowest set bit of port_hit); decision priority:
    - udp_len < HDR_BYTES → status 6, drop;
    - port_hit == 0 → status 2, drop;
    - !checksum_ok → status 1, drop;
    - otherwise accept.
  - Header-only packet (s_last was on the final header beat): CHECK → IDLE directly with pkt_done. A drop decision uses its drop status. An accept uses status 0 if udp_len==HDR_BYTES, else 4.
  - Otherwise CHECK → FORWARD (accept) or DROP.
  - FORWARD: acc with s_last → IDLE. Final count (including s_bytes) != captured udp_len → status 4, else status 0.
  - DROP: acc with s_last → IDLE; status is the reason registered in CHECK.
- Idle timeout (TIMEOUT_CYC>0):
  - counter runs in HEADER/FORWARD/DROP and clears on any acc;
  - reaching TIMEOUT_CYC → IDLE, status 5;
  - timeout and s_last in the same cycle: s_last wins.
- Control outputs (combinational from state, no lookahead):
  - parse_enable = (IDLE||HEADER) && s_valid;
  - fwd_enable = FORWARD;
  - drop_enable = DROP.
- Completion:
  - pkt_done is registered, asserted the cycle after the terminating event;
  - pkt_status updates with pkt_done and holds.
- Statistics (wrap at 2^32):
  - fwd_pkts increments on completion with status 0 or 4 where the payload was forwarded or the packet was header-only accepted;
  - drop_pkts increments on every other completion.
- Back-to-back packets: the first beat of the next packet is accepted in the IDLE cycle immediately after the terminating beat.
- rst mid-packet: immediate return to IDLE; no pkt_done; counters cleared.

Test Plan:
- BYTES_PER_BEAT=1, 8 header + 4 payload bytes, port_hit=4'b0100, checksum_ok=1, udp_len=12 → s_ready low 2 cycles after byte 8, fwd_enable for 4 beats, port_sel=2, pkt_done with status 0, byte_count=12, fwd_pkts=1.
- Same packet with checksum_ok=0 → drop_enable for 4 beats, fwd_enable never high, status 1, drop_pkts=1.
- BYTES_PER_BEAT=4: 2 header beats + last beat s_bytes=3, udp_len=12 → byte_count=11, status 4, fwd_pkts=1.
- s_last on byte 5 of header → no latch_outputs pulse, pkt_done with status 3 next cycle, byte_count=5.
- TIMEOUT_CYC=16: s_valid deasserted for 16 cycles in FORWARD → status 5, state IDLE, drop_pkts+1. Repeat with s_last on cycle 16 → status 0.
- port_hit=0 with udp_len=6, checksum_ok=0 → status 6 (priority check). Then rst asserted mid-DROP → all outputs 0, no pkt_done.
